sm_icache: RTL and testbench
============================

# sm_icache

Direct-mapped, one-word-per-line instruction cache between the schoolMIPS core's instruction port (`imAddr`/`imData`) and a slower instruction memory that uses a req/ack handshake.
- On a hit it returns the word combinationally in the same cycle.
- On a miss it runs a single-outstanding fill and forwards the arriving word in the acknowledge cycle.
- The core holds `imAddr` and discards results while `cpuReady` is low.

## Interface
Parameters
- `LINES`, 8: number of lines; power of two, ≥2.
- `INDEX_W`, 3: log2(`LINES`); tag = `cpuAddr[31:INDEX_W]`, index = `cpuAddr[INDEX_W-1:0]`.

Ports
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cpuAddr`  in  32  word address from core (`imAddr`).
- `cpuData`  out  32  instruction word to core (`imData`); valid only when `cpuReady`=1.
- `cpuReady`  out  1  `cpuData` corresponds to current `cpuAddr`.
- `flush`  in  1  synchronous invalidate-all strobe.
- `memReq`  out  1  fill request to instruction memory.
- `memAddr`  out  32  word address of fill; stable while `memReq`=1.
- `memAck`  in  1  memory acknowledge; `memData` valid in this cycle.
- `memData`  in  32  fill data.
- `missCount`  out  16  number of fills started; wraps 0xFFFF→0.

## Operation
- Storage per line: valid bit, tag (32-INDEX_W bits), 32-bit data.
  - Only valid bits are reset; tag and data arrays are not.
- `hit` = `valid[idx]` & (`tag[idx]` == `cpuAddr` tag). This is evaluated combinationally in every state.
- `cpuReady` = `hit` | `fwd`, where `fwd` = (state==FILL) & `memAck` & (`cpuAddr`==`memAddr`).
- `cpuData` = `fwd` ? `memData` : `data[idx]`.
- State machine, 2 states:
  - IDLE:
    - If !`hit` & !`flush`: latch `memAddr`←`cpuAddr`, set `memReq`←1, increment `missCount`, go to FILL.
    - If `flush`=1, no fill starts that cycle.
  - FILL:
    - Hold `memReq`=1 and `memAddr` constant until `memAck` is sampled 1.
    - In the ack cycle: write data and tag to line `memAddr[INDEX_W-1:0]`; set valid←1 unless `flush`=1 in the same cycle. Then `memReq`←0 and go to IDLE.
- Exactly one outstanding request at any time. `memAck` while in IDLE is ignored.
- `cpuAddr` changing during FILL:
  - The fill completes for the latched address and is still written.
  - The new address is looked up normally; it may hit a different valid line.
  - A miss on the new address starts its own fill only after returning to IDLE.
- `flush`:
  - Clears all valid bits at the clock edge.
  - Takes priority over a same-cycle fill write: the line is written but stays invalid.
- `hit` in IDLE keeps the state in IDLE; no memory traffic.

## Timing
- Reset (async, immediate): state=IDLE, `memReq`=0, `memAddr`=0, `missCount`=0, all valid=0. Consequently `cpuReady`=0 for any address until filled.
- Reset asserted mid-FILL aborts the fill; `memReq` drops asynchronously. A late `memAck` after reset is ignored.
- Hit latency: 0 cycles (combinational, same cycle as `cpuAddr`).
- Miss, cycle N (IDLE, miss) → cycle N+1: `memReq`=1, `memAddr` valid, state FILL.
- Ack, cycle M ≥ N+1:
  - `cpuReady`=1 via forward in cycle M.
  - Line valid from M+1; `memReq`=0 at M+1.
- Minimum miss penalty is 1 cycle (memory acking combinationally in the first request cycle).
- Back-to-back misses: a new `memReq` is asserted no earlier than M+2. `memReq` is low for at least one cycle between requests.
- `missCount` updates at the IDLE→FILL edge. Wrap-around is modulo 2^16.

## Test plan
- Cold start:
  - Stimulus: reset, then `cpuAddr`=0x00000000; memory acks 2 cycles after `memReq` with 0x24080005.
  - Response: `cpuReady`=0 until the ack cycle; `cpuData`=0x24080005 with `cpuReady`=1 in the ack cycle; `missCount`=1; next cycle a hit with `memReq`=0.
- Sequential loop:
  - Stimulus: addresses 0..7 once (8 fills), then 0..7 again.
  - Response: second pass all hits with zero latency, no `memReq`, `missCount`=8.
- Conflict:
  - Stimulus: fill 0x00000003, then access 0x0000000B (same index, `LINES`=8).
  - Response: miss, refill, `missCount`+1; a subsequent 0x00000003 access misses again.
- Address change mid-fill:
  - Stimulus: miss on 0x10, `cpuAddr`→0x01 (already valid) before ack.
  - Response: 0x01 hits immediately; fill of 0x10 still completes and 0x10 hits later without `memReq`.
- Flush:
  - Stimulus: `flush` pulse in IDLE with lines valid; separately, `flush` coincident with `memAck`.
  - Response: all prior hits become misses; the line filled in the flush cycle is not valid afterwards, though `cpuReady`/forward is still asserted in that ack cycle.
- Reset mid-fill and counter wrap:
  - Stimulus: assert `rst_n`=0 while `memReq`=1, then ack after reset; force 65536 misses.
  - Response: `memReq`=0 immediately, the ack is ignored and no line becomes valid; `missCount` returns to 0 after the 65536th miss.

Source files
------------

// File: rtl/sm_icache.sv
// Direct-mapped, one-word-per-line instruction cache for the schoolMIPS core.
// Hits return data combinationally; misses run one req/ack fill at a time.
module sm_icache #(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpuAddr,
  output logic [31:0] cpuData,
  output logic        cpuReady,
  input  logic        flush,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic [15:0] missCount
);

  localparam int TAG_W = 32 - INDEX_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e             state_q;
  logic               memReq_q;
  logic [31:0]        memAddr_q;
  logic [15:0]        missCount_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  logic [INDEX_W-1:0] idx_s;
  logic [INDEX_W-1:0] fill_idx_s;
  logic               hit_s;
  logic               fill_done_s;
  logic               fwd_s;

  always_comb begin
    idx_s       = cpuAddr[INDEX_W-1:0];
    fill_idx_s  = memAddr_q[INDEX_W-1:0];
    hit_s       = valid_q[idx_s] && (tag_q[idx_s] == cpuAddr[31:INDEX_W]);
    fill_done_s = (state_q == S_FILL) && memAck;
    fwd_s       = fill_done_s && (cpuAddr == memAddr_q);
  end

  assign cpuReady  = hit_s | fwd_s;
  assign cpuData   = fwd_s ? memData : data_q[idx_s];
  assign memReq    = memReq_q;
  assign memAddr   = memAddr_q;
  assign missCount = missCount_q;

  // Flush is applied last so it overrides the valid bit set by a same-cycle fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      memReq_q    <= 1'b0;
      memAddr_q   <= 32'd0;
      missCount_q <= 16'd0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hit_s && !flush) begin
            memAddr_q   <= cpuAddr;
            memReq_q    <= 1'b1;
            missCount_q <= missCount_q + 16'd1;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          if (memAck) begin
            valid_q[fill_idx_s] <= 1'b1;
            memReq_q            <= 1'b0;
            state_q             <= S_IDLE;
          end
        end
        default: begin
          memReq_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_done_s) begin
      tag_q[fill_idx_s]  <= memAddr_q[31:INDEX_W];
      data_q[fill_idx_s] <= memData;
    end
  end

endmodule

// File: tb/tb_sm_icache.sv
// Self-checking bench for sm_icache: directed scenarios, a line-level reference
// model compared every cycle, and literal expectations at the key points.
module tb_sm_icache;

  localparam int LINES = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpuAddr = 32'd0;
  logic [31:0] cpuData;
  logic        cpuReady;
  logic        flush = 1'b0;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck = 1'b0;
  logic [31:0] memData = 32'd0;
  logic [15:0] missCount;

  int n_checks = 0;
  int n_errors = 0;

  sm_icache #(.LINES(LINES), .INDEX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cpuAddr(cpuAddr), .cpuData(cpuData),
    .cpuReady(cpuReady), .flush(flush), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .missCount(missCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2408_0005;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each line remembers the full word address it holds.
  logic        m_val  [LINES];
  logic [31:0] m_addr [LINES];
  logic [31:0] m_data [LINES];
  logic        m_busy = 1'b0;
  logic [31:0] m_req_addr = 32'd0;
  logic [15:0] m_count = 16'd0;
  bit          cmp_en = 1'b1;

  initial for (int i = 0; i < LINES; i++) begin
    m_val[i] = 1'b0; m_addr[i] = 32'd0; m_data[i] = 32'd0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) m_val[i] = 1'b0;
      m_busy = 1'b0; m_req_addr = 32'd0; m_count = 16'd0;
    end else begin
      if (m_busy) begin
        if (memAck) begin
          m_val[m_req_addr % LINES]  = 1'b1;
          m_addr[m_req_addr % LINES] = m_req_addr;
          m_data[m_req_addr % LINES] = memData;
          m_busy = 1'b0;
        end
      end else if (!flush && !(m_val[cpuAddr % LINES] && m_addr[cpuAddr % LINES] == cpuAddr)) begin
        m_busy = 1'b1; m_req_addr = cpuAddr; m_count = m_count + 16'd1;
      end
      if (flush) for (int i = 0; i < LINES; i++) m_val[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      logic hit, fwd, rdy;
      logic [31:0] dat;
      hit = m_val[cpuAddr % LINES] && (m_addr[cpuAddr % LINES] == cpuAddr);
      fwd = m_busy && memAck && (cpuAddr == m_req_addr);
      rdy = hit || fwd;
      dat = fwd ? memData : m_data[cpuAddr % LINES];
      chk("model_cpuReady", {31'd0, cpuReady}, {31'd0, rdy});
      if (rdy) chk("model_cpuData", cpuData, dat);
      chk("model_memReq", {31'd0, memReq}, {31'd0, m_busy});
      chk("model_memAddr", memAddr, m_req_addr);
      chk("model_missCount", {16'd0, missCount}, {16'd0, m_count});
    end
  end

  // Memory responder: acks after ack_delay request cycles when enabled.
  bit mem_en = 1'b0;
  int ack_delay = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      if (memReq) begin
        if (wait_cnt >= ack_delay) begin
          memAck = 1'b1; memData = memword(memAddr); wait_cnt = 0;
        end else begin
          memAck = 1'b0; wait_cnt++;
        end
      end else begin
        memAck = 1'b0; wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic access(input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    cpuAddr = a;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpuReady === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL access_timeout: addr %h got no cpuReady, expected it within 40 cycles", a);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_memReq", {31'd0, memReq}, 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_missCount", {16'd0, missCount}, 32'd0);
    chk("rst_cpuReady", {31'd0, cpuReady}, 32'd0);

    // Cold start: ack two cycles after memReq rises
    mem_en = 1'b1; ack_delay = 2; cpuAddr = 32'd0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("cold_ready_miss", {31'd0, cpuReady}, 32'd0);
    chk("cold_noreq", {31'd0, memReq}, 32'd0);
    step(); @(negedge clk);
    chk("cold_req", {31'd0, memReq}, 32'd1);
    chk("cold_count", {16'd0, missCount}, 32'd1);
    chk("cold_ready_wait1", {31'd0, cpuReady}, 32'd0);
    step(); @(negedge clk);
    chk("cold_ready_wait2", {31'd0, cpuReady}, 32'd0);
    step(); @(negedge clk);
    chk("cold_fwd_ready", {31'd0, cpuReady}, 32'd1);
    chk("cold_fwd_data", cpuData, 32'h2408_0005);
    step(); @(negedge clk);
    chk("cold_hit_ready", {31'd0, cpuReady}, 32'd1);
    chk("cold_hit_noreq", {31'd0, memReq}, 32'd0);
    chk("cold_hit_data", cpuData, 32'h2408_0005);
    step();

    // Sequential loop: fill 1..7, then 0..7 must all hit
    ack_delay = 0;
    for (int a = 1; a < 8; a++) access(a);
    chk("loop_count_fill", {16'd0, missCount}, 32'd8);
    for (int a = 0; a < 8; a++) begin
      cpuAddr = a;
      @(negedge clk);
      chk("loop_hit_ready", {31'd0, cpuReady}, 32'd1);
      chk("loop_hit_noreq", {31'd0, memReq}, 32'd0);
      step();
    end
    chk("loop_count_hits", {16'd0, missCount}, 32'd8);

    // Conflict on index 3
    cpuAddr = 32'h0000_000B;
    @(negedge clk);
    chk("conf_miss_B", {31'd0, cpuReady}, 32'd0);
    access(32'h0000_000B);
    chk("conf_count_B", {16'd0, missCount}, 32'd9);
    cpuAddr = 32'h0000_0003;
    @(negedge clk);
    chk("conf_miss_3", {31'd0, cpuReady}, 32'd0);
    access(32'h0000_0003);
    chk("conf_count_3", {16'd0, missCount}, 32'd10);

    // Address change mid-fill
    ack_delay = 3;
    cpuAddr = 32'h0000_0010;
    step();
    cpuAddr = 32'h0000_0001;
    @(negedge clk);
    chk("mid_hit_ready", {31'd0, cpuReady}, 32'd1);
    chk("mid_hit_data", cpuData, memword(32'h0000_0001));
    chk("mid_req_held", {31'd0, memReq}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!memReq) begin seen = 1'b1; break; end
    end
    chk("mid_fill_done", {31'd0, seen}, 32'd1);
    step();
    cpuAddr = 32'h0000_0010;
    @(negedge clk);
    chk("mid_later_hit", {31'd0, cpuReady}, 32'd1);
    chk("mid_later_noreq", {31'd0, memReq}, 32'd0);
    chk("mid_count", {16'd0, missCount}, 32'd11);
    step();

    // Flush in IDLE
    cpuAddr = 32'h0000_0001;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_miss", {31'd0, cpuReady}, 32'd0);
    chk("flush_idle_noreq", {31'd0, memReq}, 32'd0);
    access(32'h0000_0001);

    // Flush coincident with memAck
    ack_delay = 2;
    cpuAddr = 32'h0000_0020;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (memAck) begin seen = 1'b1; break; end
    end
    chk("flushack_seen", {31'd0, seen}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    chk("flushack_fwd", {31'd0, cpuReady}, 32'd1);
    chk("flushack_data", cpuData, memword(32'h0000_0020));
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flushack_invalid", {31'd0, cpuReady}, 32'd0);
    access(32'h0000_0020);

    // Reset mid-fill, late ack ignored
    mem_en = 1'b0; memAck = 1'b0;
    cpuAddr = 32'h0000_0030;
    step(); step();
    chk("rstfill_req", {31'd0, memReq}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstfill_req_drop", {31'd0, memReq}, 32'd0);
    chk("rstfill_count", {16'd0, missCount}, 32'd0);
    memAck = 1'b1; memData = 32'hDEAD_BEEF;
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstfill_late_ack", {31'd0, cpuReady}, 32'd0);
    step();
    memAck = 1'b0;
    for (int a = 0; a < 8; a++) begin
      cpuAddr = a;
      @(negedge clk);
      chk("rstfill_no_valid", {31'd0, cpuReady}, 32'd0);
      step();
    end
    ack_delay = 0; mem_en = 1'b1;
    access(32'h0000_0030);

    // Counter wrap: preload near the top, then two more misses
    force dut.missCount_q = 16'hFFFE;
    m_count = 16'hFFFE;
    #1 release dut.missCount_q;
    access(32'h0000_0040);
    chk("wrap_ffff", {16'd0, missCount}, 32'h0000_FFFF);
    access(32'h0000_0048);
    chk("wrap_zero", {16'd0, missCount}, 32'd0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
